// File: rtl/reg_window_spill_fill.sv
// Spill/fill engine: moves one register window to or from a memory stack, then
// re-selects the caller's window before going idle.
module reg_window_spill_fill #(
  parameter int          DATA_W     = 16,
  parameter int          WORDS      = 4,
  parameter logic [15:0] STACK_BASE = 16'h0100,
  parameter int          MAX_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spill_req,
  input  logic              fill_req,
  input  logic [1:0]        win_sel,
  input  logic [1:0]        cur_win,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        depth,
  output logic              rf_win_en,
  output logic [1:0]        rf_win,
  output logic [1:0]        rf_reg,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SETWIN, XFER, RESTORE} stateT;

  stateT       state, nextState;
  logic [15:0] sp;
  logic [1:0]  idx;
  logic        isSpill;
  logic [1:0]  winLat;
  logic [1:0]  curLat;
  logic        stackFull, stackEmpty;
  logic        accept, rejected, lastBeat;

  assign stackFull  = (depth == 4'(MAX_DEPTH));
  assign stackEmpty = (depth == 4'd0);
  // spill_req has priority; a blocked spill is rejected even if fill_req is also set
  assign accept     = (state == IDLE) &&
                      (spill_req ? !stackFull : (fill_req && !stackEmpty));
  assign rejected   = (state == IDLE) &&
                      (spill_req ? stackFull : (fill_req && stackEmpty));
  assign lastBeat   = (idx == 2'(WORDS - 1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sp      <= STACK_BASE;
      depth   <= 4'd0;
      idx     <= 2'd0;
      isSpill <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= nextState;
      done  <= (state == RESTORE);
      err   <= rejected;
      if (accept)
        isSpill <= spill_req;
      if (state == XFER)
        idx <= idx + 2'd1;
      else
        idx <= 2'd0;
      // sp only moves once the whole window is transferred, so an abort leaves no trace
      if (state == RESTORE) begin
        if (isSpill) begin
          sp    <= sp + 16'(WORDS);
          depth <= depth + 4'd1;
        end else begin
          sp    <= sp - 16'(WORDS);
          depth <= depth - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && (spill_req || fill_req)) begin
      winLat <= win_sel;
      curLat <= cur_win;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = SETWIN;
      SETWIN:  nextState = XFER;
      XFER:    if (lastBeat) nextState = RESTORE;
      RESTORE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rf_win_en = 1'b0;
    rf_win    = 2'd0;
    rf_reg    = 2'd0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    mem_addr  = 16'd0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      SETWIN: begin
        rf_win_en = 1'b1;
        rf_win    = winLat;
      end
      XFER: begin
        rf_reg = idx;
        if (isSpill) begin
          mem_addr  = sp + {14'd0, idx};
          mem_wdata = rf_rdata;
          mem_we    = 1'b1;
        end else begin
          mem_addr = sp - 16'(WORDS) + {14'd0, idx};
          mem_re   = 1'b1;
          rf_wdata = mem_rdata;
          rf_we    = 1'b1;
        end
      end
      RESTORE: begin
        rf_win_en = 1'b1;
        rf_win    = curLat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_window_spill_fill.sv
// Randomised bench: stack-of-windows reference model feeds a response scoreboard.
module tb_reg_window_spill_fill;
  localparam int          DW    = 16;
  localparam int          WORDS = 4;
  localparam int          MAXD  = 8;
  localparam logic [15:0] BASE  = 16'h0100;

  logic clk = 0, rstN = 0;
  logic spillReq = 0, fillReq = 0;
  logic [1:0] winSel = 0, curWin = 0;
  logic busy, done, err, rfWinEn, rfWe, memWe, memRe;
  logic [3:0] depth;
  logic [1:0] rfWin, rfReg;
  logic [DW-1:0] rfRdata, rfWdata, memWdata, memRdata;
  logic [15:0] memAddr;

  reg_window_spill_fill #(.DATA_W(DW), .WORDS(WORDS), .STACK_BASE(BASE), .MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rstN), .spill_req(spillReq), .fill_req(fillReq),
    .win_sel(winSel), .cur_win(curWin), .busy(busy), .done(done), .err(err),
    .depth(depth), .rf_win_en(rfWinEn), .rf_win(rfWin), .rf_reg(rfReg),
    .rf_rdata(rfRdata), .rf_we(rfWe), .rf_wdata(rfWdata), .mem_addr(memAddr),
    .mem_we(memWe), .mem_re(memRe), .mem_wdata(memWdata), .mem_rdata(memRdata));

  always #5 clk = ~clk;

  // Register file with overlapping windows (window w covers R[2w..2w+3]) and data memory
  logic [DW-1:0] rf [0:15];
  logic [DW-1:0] rfInit [0:15];
  logic          rfLoad = 0;
  logic [1:0]    winPtr = 0;
  logic [DW-1:0] mem [0:1023];
  wire  [3:0]    rfIdx = {1'b0, winPtr, 1'b0} + {2'b00, rfReg};

  assign rfRdata  = rf[rfIdx];
  assign memRdata = mem[memAddr[9:0]];

  always @(posedge clk) begin
    if (rfLoad) rf <= rfInit;
    else if (rfWe) rf[rfIdx] <= rfWdata;
    if (rfWinEn) winPtr <= rfWin;
    if (memWe) mem[memAddr[9:0]] <= memWdata;
  end

  typedef struct {
    bit          isErr;
    bit          isSpill;
    int          depthAfter;
    int          issueCyc;
    logic [1:0]  win;
    logic [1:0]  cur;
    logic [15:0] base;
    logic [63:0] vals;
  } expT;

  expT          expQ[$];
  logic [63:0]  modelStack[$];
  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per done/err pulse
  logic       prevWinEn = 0;
  logic [1:0] prevWin = 0;
  expT        e;
  always @(negedge clk) begin
    cyc++;
    if (rstN) begin
      chk("interlock", {30'd0, rfWinEn & rfWe, memWe & memRe}, 32'd0);
      if (done || err) begin
        if (expQ.size() == 0) begin
          chk("unexpected_response", {30'd0, done, err}, 32'd0);
        end else begin
          e = expQ.pop_front();
          chk("resp_kind", {30'd0, done, err}, {30'd0, !e.isErr, e.isErr});
          chk("resp_latency", cyc - e.issueCyc, e.isErr ? 1 : WORDS + 3);
          chk("depth", {28'd0, depth}, e.depthAfter);
          chk("busy_at_resp", {31'd0, busy}, 32'd0);
          if (e.isErr) begin
            chk("err_no_enables", {28'd0, memWe, memRe, rfWe, rfWinEn}, 32'd0);
          end else begin
            chk("restore_win", {29'd0, prevWinEn, prevWin}, {29'd0, 1'b1, e.cur});
            chk("win_ptr", {30'd0, winPtr}, {30'd0, e.cur});
            for (int i = 0; i < WORDS; i++) begin
              if (e.isSpill)
                chk("spill_mem", {16'd0, mem[10'(e.base + 16'(i))]}, {16'd0, e.vals[i*16 +: 16]});
              else
                chk("fill_reg", {16'd0, rf[4'({e.win, 1'b0}) + 4'(i)]}, {16'd0, e.vals[i*16 +: 16]});
            end
          end
        end
      end
      prevWinEn = rfWinEn;
      prevWin   = rfWin;
    end
  end

  task automatic loadRegs(input bit fixed);
    for (int i = 0; i < 16; i++) rfInit[i] = 16'($urandom);
    if (fixed) begin
      rfInit[2] = 16'h00A1; rfInit[3] = 16'h00A2; rfInit[4] = 16'h00A3; rfInit[5] = 16'h00A4;
    end
    @(negedge clk); rfLoad = 1;
    @(posedge clk); #1 rfLoad = 0;
  endtask

  task automatic clearRegs();
    for (int i = 0; i < 16; i++) rfInit[i] = '0;
    @(negedge clk); rfLoad = 1;
    @(posedge clk); #1 rfLoad = 0;
  endtask

  // Build the expected response from the stack model, then issue the request
  task automatic doOp(input bit sp, input bit fl, input logic [1:0] w, input logic [1:0] c, input bit poke);
    expT x;
    @(negedge clk); #1;
    x.issueCyc = cyc; x.win = w; x.cur = c; x.vals = '0; x.base = '0;
    x.isSpill = sp; x.isErr = 0;
    if (sp) begin
      if (modelStack.size() == MAXD) x.isErr = 1;
      else begin
        for (int i = 0; i < WORDS; i++) x.vals[i*16 +: 16] = rf[2*w + i];
        x.base = BASE + 16'(modelStack.size() * WORDS);
        modelStack.push_back(x.vals);
      end
    end else begin
      if (modelStack.size() == 0) x.isErr = 1;
      else x.vals = modelStack.pop_back();
    end
    x.depthAfter = modelStack.size();
    expQ.push_back(x);
    spillReq = sp; fillReq = fl; winSel = w; curWin = c;
    @(posedge clk); #1;
    spillReq = 0; fillReq = 0;
    if (poke) begin
      repeat (2) @(negedge clk);
      #1 spillReq = 1; winSel = 2'($urandom); curWin = 2'($urandom);
      @(posedge clk); #1 spillReq = 0;
    end
    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
    if (expQ.size() != 0) begin
      chk("response_timeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) rfInit[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("reset_depth", {28'd0, depth}, 32'd0);
    chk("reset_enables", {28'd0, rfWinEn, rfWe, memWe, memRe}, 32'd0);
    chk("reset_mem_addr", {16'd0, memAddr}, 32'd0);
    rstN = 1;

    // Directed: spill window 1 then restore it into cleared registers
    loadRegs(1);
    doOp(1, 0, 2'd1, 2'd2, 0);
    clearRegs();
    doOp(0, 1, 2'd1, 2'd2, 0);
    // Underflow, fill the stack, overflow
    doOp(0, 1, 2'd0, 2'd0, 0);
    for (int n = 0; n < MAXD; n++) begin
      loadRegs(0);
      doOp(1, 0, 2'($urandom), 2'($urandom), 0);
    end
    doOp(1, 0, 2'd3, 2'd1, 0);
    for (int n = 0; n < MAXD - 1; n++) doOp(0, 1, 2'($urandom), 2'($urandom), 0);
    // Both requests at depth 1, plus an ignored request while busy
    loadRegs(0);
    doOp(1, 1, 2'd2, 2'd0, 1);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) loadRegs(0);
      doOp(r < 5, r >= 4, 2'($urandom), 2'($urandom), 0);
    end

    // Reset in the middle of XFER beat 2
    loadRegs(0);
    @(negedge clk); #1;
    spillReq = 1; winSel = 2'd0; curWin = 2'd3;
    @(posedge clk); #1 spillReq = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_beat2_we", {31'd0, memWe}, 32'd1);
    chk("abort_beat2_reg", {30'd0, rfReg}, 32'd2);
    rstN = 0;
    #1;
    chk("abort_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    chk("abort_depth", {28'd0, depth}, 32'd0);
    chk("abort_enables", {28'd0, rfWinEn, rfWe, memWe, memRe}, 32'd0);
    chk("abort_outputs", {16'd0, memAddr | memWdata | rfWdata}, 32'd0);
    modelStack.delete();
    expQ.delete();
    @(negedge clk); rstN = 1;
    loadRegs(0);
    doOp(1, 0, 2'd1, 2'd0, 0);
    doOp(0, 1, 2'd2, 2'd1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
